frame_pingpong_buffer: RTL

Double-buffered 80x60 x 16-bit frame store feeding the VGA display stage. Accepts a raster-ordered pixel stream from the sensor/processing pipeline through a valid/ready handshake into the write bank, and serves the read bank combinationally to the VGA stage's pixel-address/data port. Banks swap only at the VGA end-of-frame pulse, so frames never tear. Also generates the one-time display-start request for the VGA stage.

---
 rtl/frame_pingpong_buffer_pkg.sv | 17 +
 rtl/frame_pingpong_buffer_if.sv | 26 ++
 rtl/frame_pingpong_buffer_pingpong_ram.sv | 30 +++
 rtl/frame_pingpong_buffer.sv | 112 +++++++++++
 4 files changed

// File: rtl/frame_pingpong_buffer_pkg.sv
// Shared constants and types for the ping-pong frame buffer.
package frame_buf_pkg;

  localparam int COLS         = 80;
  localparam int ROWS         = 60;
  localparam int FRAME_PIXELS = COLS * ROWS;
  localparam int DW           = 16;
  localparam int AW           = 20;
  localparam int WCNT_W       = 13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_HOLD
  } state_t;

endpackage

// File: rtl/frame_pingpong_buffer_if.sv
// Pixel-stream and VGA-side signals of the frame buffer.
interface frame_pingpong_buffer_if;
  import frame_buf_pkg::*;

  logic          i_pix_valid;
  logic          i_pix_sof;
  logic [DW-1:0] i_pix_data;
  logic          o_pix_ready;
  logic [AW-1:0] i_rd_addr;
  logic [DW-1:0] o_rd_data;
  logic          i_frame_done;
  logic          o_start_display;
  logic          o_frame_dropped;
  logic          o_rd_bank;

  modport slave (
    input  i_pix_valid, i_pix_sof, i_pix_data, i_rd_addr, i_frame_done,
    output o_pix_ready, o_rd_data, o_start_display, o_frame_dropped, o_rd_bank
  );

  modport master (
    output i_pix_valid, i_pix_sof, i_pix_data, i_rd_addr, i_frame_done,
    input  o_pix_ready, o_rd_data, o_start_display, o_frame_dropped, o_rd_bank
  );

endinterface

// File: rtl/frame_pingpong_buffer_pingpong_ram.sv
// Two-bank frame RAM: synchronous write port, asynchronous read port.
module pingpong_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 4800,
  parameter int ADW   = 13
) (
  input  logic           clk,
  input  logic           we,
  input  logic           wr_bank,
  input  logic [ADW-1:0] wr_addr,
  input  logic [DW-1:0]  wr_data,
  input  logic           rd_bank,
  input  logic [ADW-1:0] rd_addr,
  output logic [DW-1:0]  rd_data
);

  logic [DW-1:0] mem0 [0:DEPTH-1];
  logic [DW-1:0] mem1 [0:DEPTH-1];

  // Write into the selected bank.
  always_ff @(posedge clk) begin
    if (we) begin
      if (wr_bank) mem1[wr_addr] <= wr_data;
      else         mem0[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rd_bank ? mem1[rd_addr] : mem0[rd_addr];

endmodule

// File: rtl/frame_pingpong_buffer.sv
// Double-buffered frame store between the pixel pipeline and the VGA stage.
module frame_pingpong_buffer
  import frame_buf_pkg::*;
(
  input  logic                     i_clk_25M,
  input  logic                     i_rst_n,
  frame_pingpong_buffer_if.slave   bus
);

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic              rd_bank;
  logic              rd_valid;
  logic              start_display;
  logic              frame_dropped;

  logic              beat;
  logic              we;
  logic [WCNT_W-1:0] waddr;
  logic [DW-1:0]     ram_rd_data;
  logic              rd_in_range;

  assign bus.o_pix_ready     = (state != S_HOLD);
  assign beat                = bus.i_pix_valid && (state != S_HOLD);
  assign bus.o_start_display = start_display;
  assign bus.o_frame_dropped = frame_dropped;
  assign bus.o_rd_bank       = rd_bank;

  // Write strobe and address; an SOF beat always lands at pixel 0.
  always_comb begin
    we    = 1'b0;
    waddr = wcnt;
    if (beat) begin
      case (state)
        S_IDLE: begin
          if (bus.i_pix_sof) begin
            we    = 1'b1;
            waddr = '0;
          end
        end
        S_FILL: begin
          we = 1'b1;
          if (bus.i_pix_sof) waddr = '0;
        end
        default: ;
      endcase
    end
  end

  // Fill/hold controller; banks swap only from S_HOLD.
  always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      wcnt          <= '0;
      rd_bank       <= 1'b0;
      rd_valid      <= 1'b0;
      start_display <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      frame_dropped <= 1'b0;
      case (state)
        S_IDLE: begin
          if (beat && bus.i_pix_sof) begin
            wcnt  <= WCNT_W'(1);
            state <= S_FILL;
          end
        end
        S_FILL: begin
          if (beat) begin
            if (bus.i_pix_sof) begin
              wcnt <= WCNT_W'(1);
              if (wcnt != '0) frame_dropped <= 1'b1;
            end else if (wcnt == WCNT_W'(FRAME_PIXELS - 1)) begin
              wcnt  <= '0;
              state <= S_HOLD;
            end else begin
              wcnt <= wcnt + WCNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (bus.i_frame_done || !start_display) begin
            rd_bank       <= ~rd_bank;
            rd_valid      <= 1'b1;
            start_display <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  pingpong_ram #(
    .DW    (DW),
    .DEPTH (FRAME_PIXELS),
    .ADW   (WCNT_W)
  ) u_ram (
    .clk     (i_clk_25M),
    .we      (we),
    .wr_bank (~rd_bank),
    .wr_addr (waddr),
    .wr_data (bus.i_pix_data),
    .rd_bank (rd_bank),
    .rd_addr (bus.i_rd_addr[WCNT_W-1:0]),
    .rd_data (ram_rd_data)
  );

  assign rd_in_range   = (bus.i_rd_addr < AW'(FRAME_PIXELS));
  assign bus.o_rd_data = (rd_valid && rd_in_range) ? ram_rd_data : '0;

endmodule
